secventiator_intersectie: RTL and testbench

SECVENTIATOR_INTERSECTIE -- requirements
Module: secventiator_intersectie

---
 rtl/secventiator_intersectie.sv | 132 +++++++++++++
 tb/tb_secventiator_intersectie.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/secventiator_intersectie.sv
// Two-direction intersection light sequencer: tick-timed phases, pedestrian
// shortening of green, flashing-yellow night mode and enable-gated freeze.
module secventiator_intersectie #(
   parameter int T_VERDE      = 10,
   parameter int T_GALBEN     = 3,
   parameter int T_ROSU_TOTAL = 2,
   parameter int T_VERDE_MIN  = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       enable_i,
   input  logic       tick_i,
   input  logic       cerere_pieton_i,
   input  logic       mod_noapte_i,
   output logic [1:0] w_v_o,
   output logic       tranzit_v_o,
   output logic [1:0] w_o_o,
   output logic       tranzit_o_o,
   output logic [2:0] faza_o
);

   typedef enum logic [2:0] {
      RT1      = 3'd0,
      V_VERDE  = 3'd1,
      V_GALBEN = 3'd2,
      RT2      = 3'd3,
      O_VERDE  = 3'd4,
      O_GALBEN = 3'd5,
      NOAPTE   = 3'd6
   } faza_t;

   // Counter value seen on the last tick of each phase
   localparam logic [7:0] VERDE_ULT  = 8'(T_VERDE - 1);
   localparam logic [7:0] GALBEN_ULT = 8'(T_GALBEN - 1);
   localparam logic [7:0] ROSU_ULT   = 8'(T_ROSU_TOTAL - 1);
   localparam logic [7:0] MIN_ULT    = 8'(T_VERDE_MIN - 1);

   localparam logic [1:0] ROSU     = 2'b00;
   localparam logic [1:0] GALBEN   = 2'b01;
   localparam logic [1:0] VERDE    = 2'b10;
   localparam logic [1:0] ROSU_TOT = 2'b11;

   faza_t      stare, stare_next;
   logic [7:0] contor, contor_next;
   logic       cerere, cerere_next;
   logic       expirat;

   function automatic faza_t urmatoarea(input faza_t f);
      case (f)
         RT1:      return V_VERDE;
         V_VERDE:  return V_GALBEN;
         V_GALBEN: return RT2;
         RT2:      return O_VERDE;
         O_VERDE:  return O_GALBEN;
         O_GALBEN: return RT1;
         default:  return RT1;
      endcase
   endfunction

   // Returns {vertical, horizontal} light codes for a phase
   function automatic logic [3:0] lumini(input faza_t f);
      case (f)
         V_VERDE:  return {VERDE, ROSU};
         V_GALBEN: return {GALBEN, ROSU};
         O_VERDE:  return {ROSU, VERDE};
         O_GALBEN: return {ROSU, GALBEN};
         NOAPTE:   return {GALBEN, GALBEN};
         default:  return {ROSU_TOT, ROSU_TOT};
      endcase
   endfunction

   // The latch is read as registered, so a request on a tick acts on a later tick
   always_comb begin
      expirat = 1'b0;
      case (stare)
         RT1, RT2:           expirat = (contor == ROSU_ULT);
         V_VERDE, O_VERDE:   expirat = (contor == VERDE_ULT) || (cerere && (contor >= MIN_ULT));
         V_GALBEN, O_GALBEN: expirat = (contor == GALBEN_ULT);
         default:            expirat = 1'b0;
      endcase
   end

   always_comb begin
      stare_next  = stare;
      contor_next = contor;
      cerere_next = cerere;
      if (enable_i) begin
         if (tick_i) begin
            contor_next = contor + 8'd1;
         end
         if (cerere_pieton_i && (stare != NOAPTE)) begin
            cerere_next = 1'b1;
         end
         if (mod_noapte_i) begin
            stare_next = NOAPTE;
         end else if (stare == NOAPTE) begin
            stare_next = RT1;
         end else if (tick_i && expirat) begin
            stare_next = urmatoarea(stare);
         end
         if (stare_next != stare) begin
            contor_next = 8'd0;
            if ((stare_next == RT1) || (stare_next == RT2)) begin
               cerere_next = 1'b0;
            end
         end
      end
   end

   // Outputs are decoded from the next state so they change on the transition edge
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stare       <= RT1;
         contor      <= 8'd0;
         cerere      <= 1'b0;
         w_v_o       <= ROSU_TOT;
         w_o_o       <= ROSU_TOT;
         tranzit_v_o <= 1'b0;
         tranzit_o_o <= 1'b0;
         faza_o      <= 3'd0;
      end else begin
         stare            <= stare_next;
         contor           <= contor_next;
         cerere           <= cerere_next;
         {w_v_o, w_o_o}   <= lumini(stare_next);
         tranzit_v_o      <= (stare_next == NOAPTE);
         tranzit_o_o      <= (stare_next == NOAPTE);
         faza_o           <= stare_next;
      end
   end

endmodule

// File: tb/tb_secventiator_intersectie.sv
// Bench for secventiator_intersectie: directed scenarios plus random stimulus
// checked every cycle against a phase-table reference model.
module tb_secventiator_intersectie;

   localparam int T_V   = 10;
   localparam int T_G   = 3;
   localparam int T_R   = 2;
   localparam int T_MIN = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0;
   logic       tick = 1'b0;
   logic       req = 1'b0;
   logic       noapte = 1'b0;
   logic [1:0] w_v, w_o;
   logic       tr_v, tr_o;
   logic [2:0] faza;

   secventiator_intersectie #(
      .T_VERDE(T_V), .T_GALBEN(T_G), .T_ROSU_TOTAL(T_R), .T_VERDE_MIN(T_MIN)
   ) dut (
      .clk_i(clk), .rst_i(rst), .enable_i(en), .tick_i(tick),
      .cerere_pieton_i(req), .mod_noapte_i(noapte),
      .w_v_o(w_v), .tranzit_v_o(tr_v), .w_o_o(w_o), .tranzit_o_o(tr_o), .faza_o(faza)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_ok  = 0;

   // Reference: phase durations and light codes indexed by phase number
   int dur    [0:5] = '{T_R, T_V, T_G, T_R, T_V, T_G};
   int wv_tab [0:6] = '{3, 2, 1, 3, 0, 0, 1};
   int wo_tab [0:6] = '{3, 0, 0, 3, 2, 1, 1};
   int m_faza = 0;
   int m_elapsed = 0;
   bit m_latch = 1'b0;

   always @(posedge clk or posedge rst) begin : model
      int  nxt;
      bit  iese;
      bit  verde;
      if (rst) begin
         m_faza    <= 0;
         m_elapsed <= 0;
         m_latch   <= 1'b0;
      end else if (en) begin
         verde = (m_faza == 1) || (m_faza == 4);
         if (noapte) nxt = 6;
         else if (m_faza == 6) nxt = 0;
         else begin
            iese = tick && ((m_elapsed + 1 >= dur[m_faza]) ||
                            (verde && m_latch && (m_elapsed + 1 >= T_MIN)));
            nxt = iese ? (m_faza + 1) % 6 : m_faza;
         end
         if (nxt != m_faza) begin
            m_elapsed <= 0;
            m_latch   <= (nxt == 0 || nxt == 3) ? 1'b0 : (m_latch | (req && m_faza != 6));
         end else begin
            m_elapsed <= tick ? m_elapsed + 1 : m_elapsed;
            m_latch   <= m_latch | (req && m_faza != 6);
         end
         m_faza <= nxt;
      end
   end

   task automatic verifica(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_ok++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
   endtask

   task automatic compara();
      verifica("faza", faza, m_faza);
      verifica("w_v", w_v, wv_tab[m_faza]);
      verifica("w_o", w_o, wo_tab[m_faza]);
      verifica("tranzit_v", tr_v, (m_faza == 6) ? 1 : 0);
      verifica("tranzit_o", tr_o, (m_faza == 6) ? 1 : 0);
   endtask

   // Called at a falling edge: drive inputs for the next rising edge, then check
   task automatic ciclu(input bit t, input bit r, input bit n, input bit e);
      tick = t; req = r; noapte = n; en = e;
      @(negedge clk);
      compara();
   endtask

   task automatic tick_per(input bit r, input bit n);
      ciclu(1'b1, r, n, 1'b1);
      repeat (3) ciclu(1'b0, 1'b0, n, 1'b1);
   endtask

   task automatic pana_la_faza(input int f);
      int n;
      n = 0;
      while (faza != 3'(f) && n < 200) begin
         tick_per(1'b0, 1'b0);
         n++;
      end
      verifica("atinge_faza", faza, f);
   endtask

   task automatic numara(input int f, output int n);
      n = 0;
      while (faza == 3'(f) && n < 300) begin
         tick_per(1'b0, 1'b0);
         n++;
      end
   endtask

   initial begin
      int n;
      bit noapte_r;
      #1 rst = 1'b1;
      #1;
      verifica("rst_w_v", w_v, 3);
      verifica("rst_w_o", w_o, 3);
      verifica("rst_faza", faza, 0);
      verifica("rst_tranzit", {tr_v, tr_o}, 0);
      @(negedge clk);
      rst = 1'b0;

      // Nominal cycle with defaults
      numara(0, n); verifica("dur_rt1", n, 2);
      numara(1, n); verifica("dur_v_verde", n, 10);
      numara(2, n); verifica("dur_v_galben", n, 3);
      numara(3, n); verifica("dur_rt2", n, 2);
      numara(4, n); verifica("dur_o_verde", n, 10);
      numara(5, n); verifica("dur_o_galben", n, 3);
      verifica("revine_rt1", faza, 0);

      // Pedestrian early in green: shortened to minimum, next green full
      pana_la_faza(1);
      tick_per(1'b1, 1'b0);
      numara(1, n); verifica("pieton_t1_verde", n + 1, 4);
      verifica("pieton_t1_galben", faza, 2);
      pana_la_faza(4);
      numara(4, n); verifica("o_verde_intreg", n, 10);

      // Pedestrian past minimum: exits on the following tick
      pana_la_faza(1);
      repeat (6) tick_per(1'b0, 1'b0);
      tick_per(1'b1, 1'b0);
      numara(1, n); verifica("pieton_t7_verde", n + 7, 8);

      // Night mode from O_VERDE, then back through RT1
      pana_la_faza(4);
      ciclu(1'b0, 1'b0, 1'b1, 1'b1);
      verifica("noapte_faza", faza, 6);
      verifica("noapte_w", {w_v, w_o}, 4'b0101);
      verifica("noapte_tranzit", {tr_v, tr_o}, 2'b11);
      repeat (3) tick_per(1'b0, 1'b1);
      ciclu(1'b0, 1'b0, 1'b0, 1'b1);
      verifica("noapte_iesire", faza, 0);
      numara(0, n); verifica("noapte_rt1", n, 2);
      verifica("noapte_apoi_verde", faza, 1);

      // Freeze in V_GALBEN with inputs toggling, then finish yellow
      pana_la_faza(2);
      tick_per(1'b0, 1'b0);
      repeat (20) begin
         ciclu(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
         repeat (3) ciclu(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      end
      verifica("inghetat_faza", faza, 2);
      verifica("inghetat_w_v", w_v, 1);
      noapte = 1'b0;
      numara(2, n); verifica("galben_rest", n, 2);

      // Asynchronous reset in O_GALBEN, checked before the next clock edge
      pana_la_faza(5);
      #3 rst = 1'b1;
      #1;
      verifica("arst_w", {w_v, w_o}, 4'b1111);
      verifica("arst_faza", faza, 0);
      @(negedge clk);
      rst = 1'b0;
      numara(0, n); verifica("arst_rt1", n, 2);

      // Random traffic against the reference model
      noapte_r = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 39) == 0) noapte_r = !noapte_r;
         ciclu($urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
               noapte_r, $urandom_range(0, 9) != 0);
      end

      $display("%0d/%0d checks passed", n_ok, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got 0 expected 1");
      $fatal(1, "timeout");
   end

endmodule
